// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADJ_THRESH  = 4'd5;
    localparam logic [3:0]  ADJ_ADD     = 4'd3;

    // Smallest digit count whose decimal range covers 2**width-1.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned maxv;
        longint unsigned p;
        int unsigned     d;
        maxv = (64'd1 << width) - 64'd1;
        p    = 64'd10;
        d    = 1;
        while (p <= maxv) begin
            p = p * 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// valid/ready on both sides with a single conversion in flight.
module bin2bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SH_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_param_err
        $error("bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
    end

    state_t           state;
    logic [SH_W-1:0]  shreg;
    logic [SH_W-1:0]  shreg_nxt;
    logic [CNT_W-1:0] count;
    logic [BCD_W-1:0] digits_adj;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (shreg[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .dout_c (digits_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Adjusted digits over the untouched binary tail, shifted by one.
    assign shreg_nxt = {digits_adj, shreg[WIDTH-1:0]} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_bcd   <= '0;
            shreg     <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        shreg    <= {BCD_W'(0), in_bin};
                        count    <= CNT_W'(WIDTH);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shreg_nxt;
                    count <= count - CNT_W'(1);
                    // Last step: capture straight from the shift result.
                    if (count == CNT_W'(1)) begin
                        out_bcd   <= shreg_nxt[SH_W-1 -: BCD_W];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Scoreboard bench for bin2bcd_seq_ctrl: 8-bit/3-digit directed cases plus
// an exhaustive 4-bit/2-digit sweep.
module tb_bin2bcd_seq_ctrl;

    localparam int unsigned W8 = 8;
    localparam int unsigned D8 = 3;
    localparam int unsigned W4 = 4;
    localparam int unsigned D4 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            in_valid, in_ready, out_valid, out_ready, busy;
    logic [W8-1:0]   in_bin;
    logic [4*D8-1:0] out_bcd;

    logic            in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [W4-1:0]   in_bin4;
    logic [4*D4-1:0] out_bcd4;

    bin2bcd_seq_ctrl #(.WIDTH(W8), .DIGITS(D8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .busy(busy)
    );

    bin2bcd_seq_ctrl #(.WIDTH(W4), .DIGITS(D4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_bin(in_bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_bcd(out_bcd4), .busy(busy4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [4*D8-1:0] exp_q[$];
    logic [4*D4-1:0] exp4_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal-digit golden models.
    function automatic logic [4*D8-1:0] bcd3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [4*D4-1:0] bcd2(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic send8(input logic [W8-1:0] v, output int acc);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = v;
        exp_q.push_back(bcd3(int'(v)));
        tick();
        acc      = cyc;
        in_valid = 1'b0;
        in_bin   = W8'($urandom);
    endtask

    task automatic pop8(output logic [4*D8-1:0] e);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Waits for a result, checks latency/busy/value, then completes the handshake.
    task automatic recv8(input int acc, input int hold);
        int n = 0;
        logic [4*D8-1:0] e;
        while (!out_valid && n < 100) begin
            chk("busy_in_conv", 32'(busy), 32'd1);
            tick(); n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(cyc - acc), 32'(W8));
        chk("busy_done", 32'(busy), 32'd0);
        pop8(e);
        chk("out_bcd", 32'(out_bcd), 32'(e));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_bcd", 32'(out_bcd), 32'(e));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handshake_clears", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("bcd_kept", 32'(out_bcd), 32'(e));
    endtask

    initial begin
        int acc;
        int n;
        logic [4*D8-1:0] e;
        logic [4*D4-1:0] e4;
        int vals[4] = '{0, 9, 99, 100};

        rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_bin4 = '0; out_ready4 = 1'b0;

        // Reset state and registered in_ready release.
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'h000);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_post_edge", 32'(in_ready), 32'd1);

        // Max value with busy/latency checks.
        send8(8'd255, acc);
        recv8(acc, 0);

        foreach (vals[i]) begin
            send8(W8'(vals[i]), acc);
            recv8(acc, 0);
        end

        // out_ready already high when the result appears.
        send8(8'd128, acc);
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("early_ready_valid", 32'(out_valid), 32'd1);
        chk("early_ready_latency", 32'(cyc - acc), 32'(W8));
        pop8(e);
        chk("early_ready_bcd", 32'(out_bcd), 32'(e));
        tick();
        out_ready = 1'b0;
        chk("early_ready_1cyc_hold", 32'(out_valid), 32'd0);
        chk("early_ready_in_ready", 32'(in_ready), 32'd1);

        // Back-pressure with a pending operand held on the input.
        send8(8'd57, acc);
        in_valid = 1'b1;
        in_bin   = 8'd77;
        recv8(acc, 5);
        exp_q.push_back(bcd3(77));
        tick();
        acc      = cyc;
        in_valid = 1'b0;
        chk("pending_accepted", 32'(busy), 32'd1);
        recv8(acc, 0);

        // Reset in the middle of a conversion.
        send8(8'd200, acc);
        repeat (3) tick();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        pop8(e);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_out_bcd", 32'(out_bcd), 32'h000);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (W8 + 2) begin
            tick();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send8(8'd42, acc);
        recv8(acc, 0);

        // Exhaustive 4-bit / 2-digit sweep.
        for (int v = 0; v < 16; v++) begin
            n = 0;
            while (!in_ready4 && n < 50) begin tick(); n++; end
            chk("w4_in_ready", 32'(in_ready4), 32'd1);
            in_valid4 = 1'b1;
            in_bin4   = W4'(v);
            exp4_q.push_back(bcd2(v));
            tick();
            acc       = cyc;
            in_valid4 = 1'b0;
            in_bin4   = W4'($urandom);
            n = 0;
            while (!out_valid4 && n < 50) begin tick(); n++; end
            chk("w4_latency", 32'(cyc - acc), 32'(W4));
            e4 = (exp4_q.size() != 0) ? exp4_q.pop_front() : 8'hFF;
            chk("w4_out_bcd", 32'(out_bcd4), 32'(e4));
            out_ready4 = 1'b1;
            tick();
            out_ready4 = 1'b0;
            chk("w4_handshake", 32'(out_valid4), 32'd0);
        end

        chk("scoreboard_drained", 32'(exp_q.size() + exp4_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
